uart_tx_core: RTL and testbench

Standalone UART transmitter: takes one byte per handshake and serializes it on `tx` as start, DBIT data bits LSB first, and stop. It is the transmit-side counterpart to the UART receive path and shares the same `dvsr`/`enable` baud convention: 16 oversample ticks per bit. It serves as the TX engine behind the transmit FIFO, or as a far-end stimulus source driving the `rx` pin of the UART under test.

---
 rtl/uart_tx_core.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart_tx_core.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
//
// Standalone UART transmitter. Takes one DBIT-wide word per tx_start/tx_ready
// handshake and shifts it out on `tx` as: start bit (low), DBIT data bits LSB
// first, optional even-parity bit, then a stop period of SB_TICK oversample
// ticks (high). The baud generator makes one oversample tick every dvsr+1
// clocks, and each bit lasts 16 ticks.
//
// Parameters:
//   DBIT     data bits per frame (5..8)
//   SB_TICK  stop length in oversample ticks (16, 24 or 32)
//
// Optional feature macro:
//   UART_TX_PARITY_EN  adds a 16-tick even-parity bit between DATA and STOP.
//                      When it is undefined there is no parity state or logic.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   dvsr[15:0]    baud divisor, one oversample tick every dvsr+1 clocks
//   enable        baud generator run enable; 0 pauses the frame in place
//   tx_start      request to send din (accepted when tx_ready is high)
//   din[DBIT-1:0] word to transmit, sampled only on the accept cycle
//   tx_ready      core idle, tx_start will be accepted
//   tx_done_tick  one-cycle pulse on the last clock of the stop period
//   tx            registered serial output, idle high
// -----------------------------------------------------------------------------
module uart_tx_core #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     dvsr,
    input  logic            enable,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx_ready,
    output logic            tx_done_tick,
    output logic            tx
);

    // state    | meaning
    // ---------+----------------------------------------------------------
    // ST_IDLE  | line high, tx_ready high, waiting for tx_start
    // ST_START | start bit (low) for 16 ticks
    // ST_DATA  | data bit shift_q[0] for 16 ticks each, DBIT bits
    // ST_PARITY| even parity of the latched word for 16 ticks (macro only)
    // ST_STOP  | stop period (high) for SB_TICK ticks
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
    } state_t;
`endif

    localparam logic [4:0] TICK_LAST = 5'd15;
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DBIT - 1);

    state_t          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [4:0]      s_q, s_d;
    logic [2:0]      n_q, n_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    logic            tick;
    logic            accept;
    logic            stop_end;

    // ready_q is only ever high in ST_IDLE, so it alone qualifies the handshake.
    assign accept = tx_start && ready_q;
    assign tick   = enable && (cnt_q == dvsr);

    // The done cycle is itself the last clock of the stop period, so STOP is
    // left one clock before its final tick would land. That lets a tx_start
    // in the done cycle begin the next start bit with no idle gap while the
    // stop period still totals SB_TICK*(dvsr+1) clocks.
    always_comb begin
        stop_end = 1'b0;
        if (enable) begin
            if (dvsr != 16'd0) begin
                stop_end = (s_q == STOP_LAST) && (cnt_q == dvsr - 16'd1);
            end else begin
                stop_end = (s_q == STOP_LAST - 5'd1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shift_d = shift_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        // Free-running baud counter, restarted on accept so the start bit
        // is a full 16*(dvsr+1) clocks.
        if (accept) begin
            cnt_d = 16'd0;
        end else if (enable) begin
            cnt_d = (cnt_q == dvsr) ? 16'd0 : cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_START;
                    s_d     = 5'd0;
                    n_d     = 3'd0;
                    shift_d = din;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^din;
`endif
                end
            end
            ST_START: begin
                if (tick) begin
                    if (s_q == TICK_LAST) begin
                        state_d = ST_DATA;
                        s_d     = 5'd0;
                        n_d     = 3'd0;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s_q == TICK_LAST) begin
                        s_d     = 5'd0;
                        shift_d = shift_q >> 1;
                        if (n_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    if (s_q == TICK_LAST) begin
                        state_d = ST_STOP;
                        s_d     = 5'd0;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (stop_end) begin
                    state_d = ST_IDLE;
                    s_d     = 5'd0;
                    done_d  = 1'b1;
                end else if (tick) begin
                    s_d = s_q + 5'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = 5'd0;
                n_d     = 3'd0;
            end
        endcase

        // Line level follows the next state so tx is a plain flop output.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:   tx_d = 1'b1;
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 16'd0;
            s_q      <= 5'd0;
            n_q      <= 3'd0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            n_q      <= n_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx           = tx_q;
    assign tx_ready     = ready_q;
    assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_core
//
// Directed bench for uart_tx_core (DBIT=8, SB_TICK=16). Clocks inside a frame
// are numbered from 1, clock 1 being the cycle right after the accept edge;
// outputs are sampled 1 ns after each rising edge. Expected bit patterns are
// written out by hand, slot 0 = start bit, then data LSB first, [parity],
// and the last slot = stop bit.
// -----------------------------------------------------------------------------
module tb_uart_tx_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] dvsr = 16'd0;
    logic        enable = 1'b0;
    logic        tx_start = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        tx_ready;
    logic        tx_done_tick;
    logic        tx;

`ifdef UART_TX_PARITY_EN
    localparam int          NSLOT = 11;
    localparam int          FLEN  = 176;
    localparam int          FLEN3 = 704;
    localparam logic [10:0] P55   = 11'h4AA;
    localparam logic [10:0] PA3   = 11'h546;
    localparam logic [10:0] P5A   = 11'h4B4;
    localparam logic [10:0] P07   = 11'h60E;
`else
    localparam int          NSLOT = 10;
    localparam int          FLEN  = 160;
    localparam int          FLEN3 = 640;
    localparam logic [10:0] P55   = 11'h2AA;
    localparam logic [10:0] PA3   = 11'h346;
    localparam logic [10:0] P5A   = 11'h2B4;
    localparam logic [10:0] P07   = 11'h20E;
`endif

    uart_tx_core #(.DBIT(8), .SB_TICK(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .dvsr         (dvsr),
        .enable       (enable),
        .tx_start     (tx_start),
        .din          (din),
        .tx_ready     (tx_ready),
        .tx_done_tick (tx_done_tick),
        .tx           (tx)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n = 0;
    bit hold_on = 1'b0;
    int drop_at = 0;
    int busy_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
        if (hold_on) begin
            if (tx_ready) busy_bad++;
            if (n >= drop_at) begin
                tx_start = 1'b0;
                hold_on  = 1'b0;
            end
        end
    endtask

    task automatic send(input logic [7:0] d);
        int w = 0;
        while (!tx_ready && w < 1000) begin
            step();
            w++;
        end
        if (!tx_ready) check_eq("send_wait_ready", {31'd0, tx_ready}, 32'd1);
        tx_start = 1'b1;
        din      = d;
        step();
        tx_start = 1'b0;
        n = 1;
    endtask

    task automatic wait_done(input string tag, input int exp_len);
        int limit = exp_len + 50;
        while (!tx_done_tick && n < limit) step();
        check_eq({tag, "_done_at"}, n, exp_len);
        check_eq({tag, "_ready_at_done"}, {31'd0, tx_ready}, 32'd1);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input logic [15:0] dv,
                             input logic [10:0] exp_bits, input int exp_len, input bit hold);
        int half;
        int bitlen;
        int target;
        int bad;
        dvsr   = dv;
        half   = 8 * (int'(dv) + 1);
        bitlen = 16 * (int'(dv) + 1);
        send(d);
        if (hold) begin
            tx_start = 1'b1;
            din      = 8'hFF;
            busy_bad = 0;
            drop_at  = exp_len - 20;
            hold_on  = 1'b1;
        end
        for (int i = 0; i < NSLOT; i++) begin
            target = half + i * bitlen;
            while (n < target) step();
            check_eq($sformatf("%s_slot%0d", tag, i), {31'd0, tx}, {31'd0, exp_bits[i]});
        end
        wait_done(tag, exp_len);
        if (hold) begin
            check_eq({tag, "_busy_ready"}, busy_bad, 0);
            bad = 0;
            repeat (40) begin
                step();
                if (tx !== 1'b1) bad++;
            end
            check_eq({tag, "_no_queued_frame"}, bad, 0);
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int d1;

        // Reset state and idle line.
        reset  = 1'b1;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tx", {31'd0, tx}, 32'd1);
        check_eq("rst_ready", {31'd0, tx_ready}, 32'd1);
        check_eq("rst_done", {31'd0, tx_done_tick}, 32'd0);
        reset = 1'b0;
        bad = 0;
        repeat (50) begin
            step();
            if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_done_tick !== 1'b0) bad++;
        end
        check_eq("idle_50", bad, 0);

        // dvsr=0, 0x55.
        run_frame("f55", 8'h55, 16'd0, P55, FLEN, 1'b0);

        // dvsr=3, 0xA3 with tx_start held busy and din=0xFF.
        run_frame("fa3", 8'hA3, 16'd3, PA3, FLEN3, 1'b1);

        // Back-to-back: 0x01 then 0x80 with tx_start held high.
        dvsr     = 16'd0;
        tx_start = 1'b1;
        din      = 8'h01;
        step();
        n = 1;
        while (1) begin
            if (n == 24) check_eq("b2b_a_bit0", {31'd0, tx}, 32'd1);
            if (tx_done_tick || n >= 400) break;
            step();
        end
        d1 = n;
        check_eq("b2b_a_done_at", d1, FLEN);
        din = 8'h80;
        step();
        check_eq("b2b_start_no_gap", {31'd0, tx}, 32'd0);
        check_eq("b2b_busy", {31'd0, tx_ready}, 32'd0);
        while (1) begin
            step();
            if (n == d1 + 24)  check_eq("b2b_b_bit0", {31'd0, tx}, 32'd0);
            if (n == d1 + 136) check_eq("b2b_b_bit7", {31'd0, tx}, 32'd1);
            if (tx_done_tick || n >= d1 + 400) break;
        end
        tx_start = 1'b0;
        check_eq("b2b_done_spacing", n - d1, FLEN);
        repeat (5) step();
        check_eq("b2b_idle_ready", {31'd0, tx_ready}, 32'd1);
        check_eq("b2b_idle_tx", {31'd0, tx}, 32'd1);

        // Enable pause during data bit 2 of 0x0F.
        dvsr = 16'd0;
        send(8'h0F);
        while (n < 55) step();
        enable = 1'b0;
        bad = 0;
        repeat (100) begin
            step();
            if (tx !== 1'b1 || tx_ready !== 1'b0) bad++;
        end
        enable = 1'b1;
        check_eq("pause_hold", bad, 0);
        wait_done("f0f", FLEN + 100);

        // Reset mid-frame on 0x00.
        send(8'h00);
        while (n < 70) step();
        check_eq("mid_tx_low", {31'd0, tx}, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("midrst_tx", {31'd0, tx}, 32'd1);
        check_eq("midrst_ready", {31'd0, tx_ready}, 32'd1);
        check_eq("midrst_done", {31'd0, tx_done_tick}, 32'd0);
        bad = 0;
        repeat (200) begin
            step();
            if (tx_done_tick !== 1'b0 || tx !== 1'b1) bad++;
        end
        check_eq("midrst_no_done", bad, 0);
        run_frame("f5a", 8'h5A, 16'd0, P5A, FLEN, 1'b0);

        // 0x07: odd number of ones, parity bit 1 when enabled.
        run_frame("f07", 8'h07, 16'd0, P07, FLEN, 1'b0);

        repeat (5) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
